oled_glyph_streamer: RTL and testbench

Downstream consumer of the character glyph ROM. It accepts one ASCII character plus a text-cell position per handshake and drives the ROM address. It registers the returned 64-bit glyph, then emits a byte stream for the OLED SPI byte transmitter: a 6-byte addressing command preamble followed by 8 glyph column bytes. It sits between the text/message sequencer and the SPI byte serializer.

---
 rtl/oled_pkg.sv | 22 ++
 rtl/oled_glyph_streamer_if.sv | 32 +++
 rtl/glyph_shift_reg.sv | 41 ++++
 rtl/oled_glyph_streamer.sv | 156 +++++++++++++++
 tb/tb_oled_glyph_streamer.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED glyph streamer: FSM states,
// SSD1306-style addressing opcodes and the byte counts of one character.
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMD  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic [7:0] CMD_SET_COL  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE = 8'h22;
    localparam int         CMD_LEN      = 6;
    localparam int         GLYPH_BYTES  = 8;

    // First pixel column of a text cell, in the display's 8-bit column space.
    function automatic logic [7:0] col_base(input logic [3:0] col, input int glyph_w);
        return 8'(int'(col) * glyph_w);
    endfunction

endpackage

// File: rtl/oled_glyph_streamer_if.sv
// Handshake bundles of the glyph streamer: character requests in, SPI bytes out.
// With GLYPH_INVERT_EN defined the request bundle also carries char_inv.
interface oled_char_if;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] char_code;
    logic [3:0] char_col;
    logic [1:0] char_page;
`ifdef GLYPH_INVERT_EN
    logic       char_inv;

    modport master (output char_valid, char_code, char_col, char_page, char_inv,
                    input  char_ready);
    modport slave  (input  char_valid, char_code, char_col, char_page, char_inv,
                    output char_ready);
`else
    modport master (output char_valid, char_code, char_col, char_page,
                    input  char_ready);
    modport slave  (input  char_valid, char_code, char_col, char_page,
                    output char_ready);
`endif
endinterface

interface oled_byte_if;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_dc;

    modport master (output byte_valid, byte_data, byte_dc, input  byte_ready);
    modport slave  (input  byte_valid, byte_data, byte_dc, output byte_ready);
endinterface

// File: rtl/glyph_shift_reg.sv
// 64-bit glyph holding register: parallel load from the ROM word, shift by one
// byte per data transfer; top_byte is always the next column to send.
module glyph_shift_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [63:0] din,
    output logic [7:0]  top_byte
);
    // lanes[0] holds din[63:56], the leftmost pixel column.
    logic [7:0][7:0] lanes;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic [7:0] shift_in;

            if (gi == 7) begin : g_tail
                assign shift_in = 8'h00;
            end else begin : g_body
                assign shift_in = lanes[gi+1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= 8'h00;
                end else if (load) begin
                    lane_reg <= din[8*(7-gi) +: 8];
                end else if (shift) begin
                    lane_reg <= shift_in;
                end
            end

            assign lanes[gi] = lane_reg;
        end
    endgenerate

    assign top_byte = lanes[0];

endmodule

// File: rtl/oled_glyph_streamer.sv
// Turns one character request into a 6-byte column/page addressing preamble
// followed by 8 glyph column bytes. Macro GLYPH_INVERT_EN adds char_inv (inverted cell).
module oled_glyph_streamer
    import oled_pkg::*;
#(
    parameter int COLS    = 16,
    parameter int PAGES   = 4,
    parameter int GLYPH_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    oled_char_if.slave  char_bus,
    oled_byte_if.master byte_bus,
    output logic [6:0]  rom_addr,
    input  logic [63:0] rom_data,
    output logic        busy,
    output logic        drop
);
    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic [6:0] code_reg;
    logic [3:0] col_reg;
    logic [1:0] page_reg;
    logic       drop_reg;

    logic       ready;
    logic       accept;
    logic       in_range;
    logic       glyph_load;
    logic       glyph_shift;
    logic [7:0] glyph_top;
    logic [7:0] data_mask;
    logic [7:0] cmd_byte;
    logic [7:0] col_lo;

`ifdef GLYPH_INVERT_EN
    logic       inv_reg;
`endif

    // Range is judged on the live request so a bad one never leaves IDLE.
    assign in_range = (int'(char_bus.char_col) < COLS) && (int'(char_bus.char_page) < PAGES);
    assign accept   = char_bus.char_valid && ready;

    assign char_bus.char_ready = ready;
    assign busy     = (state_reg != IDLE);
    assign drop     = drop_reg;
    assign rom_addr = code_reg;
    assign col_lo   = col_base(col_reg, GLYPH_W);

`ifdef GLYPH_INVERT_EN
    assign data_mask = {8{inv_reg}};
`else
    assign data_mask = 8'h00;
`endif

    glyph_shift_reg u_glyph (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (glyph_load),
        .shift    (glyph_shift),
        .din      (rom_data),
        .top_byte (glyph_top)
    );

    always_comb begin
        cmd_byte = CMD_SET_COL;
        case (idx_reg)
            4'd0:    cmd_byte = CMD_SET_COL;
            4'd1:    cmd_byte = col_lo;
            4'd2:    cmd_byte = col_lo + 8'(GLYPH_W - 1);
            4'd3:    cmd_byte = CMD_SET_PAGE;
            default: cmd_byte = {6'd0, page_reg};
        endcase
    end

    always_comb begin
        state_next          = state_reg;
        idx_next            = idx_reg;
        ready               = 1'b0;
        glyph_load          = 1'b0;
        glyph_shift         = 1'b0;
        byte_bus.byte_valid = 1'b0;
        byte_bus.byte_data  = 8'h00;
        byte_bus.byte_dc    = 1'b0;

        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (char_bus.char_valid && in_range) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                glyph_load = 1'b1;
                idx_next   = 4'd0;
                state_next = CMD;
            end
            CMD: begin
                byte_bus.byte_valid = 1'b1;
                byte_bus.byte_data  = cmd_byte;
                if (byte_bus.byte_ready) begin
                    if (idx_reg == 4'(CMD_LEN - 1)) begin
                        idx_next   = 4'd0;
                        state_next = DATA;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                byte_bus.byte_valid = 1'b1;
                byte_bus.byte_dc    = 1'b1;
                byte_bus.byte_data  = glyph_top ^ data_mask;
                if (byte_bus.byte_ready) begin
                    glyph_shift = 1'b1;
                    if (idx_reg == 4'(GLYPH_BYTES - 1)) begin
                        idx_next   = 4'd0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
            code_reg  <= 7'd0;
            col_reg   <= 4'd0;
            page_reg  <= 2'd0;
            drop_reg  <= 1'b0;
`ifdef GLYPH_INVERT_EN
            inv_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            drop_reg  <= accept && !in_range;
            if (accept) begin
                code_reg <= char_bus.char_code;
                col_reg  <= char_bus.char_col;
                page_reg <= char_bus.char_page;
`ifdef GLYPH_INVERT_EN
                inv_reg  <= char_bus.char_inv;
`endif
            end
        end
    end

endmodule

// File: tb/tb_oled_glyph_streamer.sv
// Self-checking bench: spec vectors, multi-cycle corner sequences and random
// requests against a queue-based reference of the expected byte stream.
`timescale 1ns/1ps
module tb_oled_glyph_streamer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Stimulus variables, routed to the selected DUT (sel=1: small-geometry DUT).
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] in_code = '0;
    logic [3:0] in_col = '0;
    logic [1:0] in_page = '0;
    logic       in_inv = 1'b0;
    logic       byte_rdy = 1'b1;
    int         mode = 0;

    oled_char_if cif_m ();
    oled_byte_if bif_m ();
    oled_char_if cif_d ();
    oled_byte_if bif_d ();

    logic [6:0]  rom_addr_m, rom_addr_d;
    logic [63:0] rom_data_m, rom_data_d;
    logic        busy_m, drop_m, busy_d, drop_d;

    oled_glyph_streamer u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .char_bus (cif_m),
        .byte_bus (bif_m),
        .rom_addr (rom_addr_m),
        .rom_data (rom_data_m),
        .busy     (busy_m),
        .drop     (drop_m)
    );

    oled_glyph_streamer #(.COLS(10), .PAGES(3)) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .char_bus (cif_d),
        .byte_bus (bif_d),
        .rom_addr (rom_addr_d),
        .rom_data (rom_data_d),
        .busy     (busy_d),
        .drop     (drop_d)
    );

    // Character ROM model of the surrounding system.
    function automatic logic [63:0] rom_glyph(input logic [6:0] c);
        logic [63:0] g;
        if (c <= 7'd32) return 64'h0;
        case (c)
            7'h41:   return 64'h7C1211127C000000;
            7'h42:   return 64'h417F494949493600;
            7'h48:   return 64'h7F0808087F000000;
            7'h69:   return 64'h0000447D40000000;
            7'h7F:   return 64'hAA55AA55AA55AA55;
            default: begin
                for (int b = 0; b < 8; b++) g[8*b +: 8] = 8'(int'(c) * 13 + b * 41) ^ 8'hC3;
                return g;
            end
        endcase
    endfunction

    assign rom_data_m = rom_glyph(rom_addr_m);
    assign rom_data_d = rom_glyph(rom_addr_d);

    assign cif_m.char_valid = in_valid && !sel;
    assign cif_d.char_valid = in_valid && sel;
    assign cif_m.char_code  = in_code;
    assign cif_d.char_code  = in_code;
    assign cif_m.char_col   = in_col;
    assign cif_d.char_col   = in_col;
    assign cif_m.char_page  = in_page;
    assign cif_d.char_page  = in_page;
`ifdef GLYPH_INVERT_EN
    assign cif_m.char_inv   = in_inv;
    assign cif_d.char_inv   = in_inv;
`endif
    assign bif_m.byte_ready = byte_rdy;
    assign bif_d.byte_ready = byte_rdy;

    logic       o_valid, o_dc, o_cready, o_busy, o_drop;
    logic [7:0] o_data;
    assign o_valid  = sel ? bif_d.byte_valid : bif_m.byte_valid;
    assign o_dc     = sel ? bif_d.byte_dc    : bif_m.byte_dc;
    assign o_data   = sel ? bif_d.byte_data  : bif_m.byte_data;
    assign o_cready = sel ? cif_d.char_ready : cif_m.char_ready;
    assign o_busy   = sel ? busy_d : busy_m;
    assign o_drop   = sel ? drop_d : drop_m;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       byte_rdy = 1'b1;
                1:       byte_rdy = ~byte_rdy;
                default: byte_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Transfer monitor: records bytes and checks hold-while-stalled behaviour.
    initial begin
        logic       stall_prev;
        logic [8:0] prev_byte;
        stall_prev = 1'b0;
        prev_byte  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 32'(o_valid), 32'd1);
                    check("hold_byte", 32'({o_dc, o_data}), 32'(prev_byte));
                end
                if (o_valid) begin
                    check("ready_low_while_streaming", 32'(o_cready), 32'd0);
                    if (byte_rdy) got_q.push_back({o_dc, o_data});
                end
                stall_prev = o_valid && !byte_rdy;
                prev_byte  = {o_dc, o_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference stream of one character, built straight from the display rules.
    task automatic add_expected(input logic [6:0] c, input logic [3:0] col,
                                input logic [1:0] pg, input logic inv);
        logic [63:0] g;
        logic [7:0]  mask;
        g = rom_glyph(c);
`ifdef GLYPH_INVERT_EN
        mask = inv ? 8'hFF : 8'h00;
`else
        mask = inv ? 8'h00 : 8'h00;
`endif
        exp_q.push_back({1'b0, 8'h21});
        exp_q.push_back({1'b0, 8'(int'(col) * 8)});
        exp_q.push_back({1'b0, 8'(int'(col) * 8 + 7)});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 6'd0, pg});
        exp_q.push_back({1'b0, 6'd0, pg});
        for (int b = 0; b < 8; b++) exp_q.push_back({1'b1, g[63-8*b -: 8] ^ mask});
    endtask

    task automatic send_char(input logic [6:0] c, input logic [3:0] col,
                             input logic [1:0] pg, input logic inv);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_code  = c;
        in_col   = col;
        in_page  = pg;
        in_inv   = inv;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_cready) break;
        end
        if (n == 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int nbytes);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (got_q.size() >= nbytes && !o_busy) break;
        end
        if (k == 3000) check("stream_timeout", 32'(got_q.size()), 32'(nbytes));
    endtask

    task automatic compare_streams(input string name);
        check($sformatf("%s_count", name), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        $display("[TB] %s: %0d bytes compared", name, exp_q.size());
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [6:0]  code;
        logic [3:0]  col;
        logic [1:0]  page;
        logic        inv;
        logic [47:0] cmd;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int acc_first;

        vecs.push_back('{7'h42, 4'd2,  2'd1, 1'b0, 48'h211017220101, 64'h417F494949493600});
        vecs.push_back('{7'h7F, 4'd15, 2'd3, 1'b0, 48'h21787F220303, 64'hAA55AA55AA55AA55});
        vecs.push_back('{7'h20, 4'd0,  2'd0, 1'b0, 48'h210007220000, 64'h0000000000000000});
`ifdef GLYPH_INVERT_EN
        vecs.push_back('{7'h7F, 4'd15, 2'd3, 1'b1, 48'h21787F220303, 64'h55AA55AA55AA55AA});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bif_m.byte_valid), 32'd0);
        check("rst_ready", 32'(cif_m.char_ready), 32'd1);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_drop", 32'(drop_m), 32'd0);
        check("rst_data", 32'({bif_m.byte_dc, bif_m.byte_data}), 32'd0);
        check("rst_rom_addr", 32'(rom_addr_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors with byte_ready tied high.
        mode = 0;
        foreach (vecs[v]) begin
            for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, vecs[v].cmd[47-8*i -: 8]});
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, vecs[v].data[63-8*i -: 8]});
            send_char(vecs[v].code, vecs[v].col, vecs[v].page, vecs[v].inv);
            wait_done(14);
            compare_streams($sformatf("vec%0d", v));
        end

        // First byte two cycles after accept.
        send_char(7'h42, 4'd2, 2'd1, 1'b0);
        @(negedge clk);
        check("lat_load_valid", 32'(o_valid), 32'd0);
        check("lat_load_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        check("lat_first_valid", 32'(o_valid), 32'd1);
        add_expected(7'h42, 4'd2, 2'd1, 1'b0);
        wait_done(14);
        compare_streams("latency_B");

        // Alternating byte_ready.
        mode = 1;
        add_expected(7'h42, 4'd2, 2'd1, 1'b0);
        send_char(7'h42, 4'd2, 2'd1, 1'b0);
        wait_done(14);
        compare_streams("toggle_B");
        mode = 0;

        // Back-to-back requests.
        add_expected(7'h48, 4'd4, 2'd2, 1'b0);
        add_expected(7'h69, 4'd5, 2'd2, 1'b0);
        send_char(7'h48, 4'd4, 2'd2, 1'b0);
        acc_first = acc_cyc;
        send_char(7'h69, 4'd5, 2'd2, 1'b0);
        check("b2b_gap", 32'(acc_cyc - acc_first), 32'd16);
        wait_done(28);
        compare_streams("b2b_Hi");

        // Out-of-range requests on the 10-column, 3-page instance.
        sel = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_code  = 7'h41;
            in_col   = (t == 0) ? 4'd12 : 4'd0;
            in_page  = (t == 0) ? 2'd0 : 2'd3;
            @(negedge clk);
            check("drop_pre", 32'(o_drop), 32'd0);
            check("drop_ready", 32'(o_cready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("drop_pulse", 32'(o_drop), 32'd1);
            check("drop_no_valid", 32'(o_valid), 32'd0);
            check("drop_busy", 32'(o_busy), 32'd0);
            @(negedge clk);
            check("drop_end", 32'(o_drop), 32'd0);
            check("drop_no_valid2", 32'(o_valid), 32'd0);
        end
        check("drop_no_bytes", 32'(got_q.size()), 32'd0);
        add_expected(7'h42, 4'd9, 2'd2, 1'b0);
        send_char(7'h42, 4'd9, 2'd2, 1'b0);
        wait_done(14);
        compare_streams("after_drop");
        sel = 1'b0;

        // Reset after the 3rd data byte of 'A'.
        send_char(7'h41, 4'd1, 2'd0, 1'b0);
        for (int k = 0; k < 100 && got_q.size() < 9; k++) @(negedge clk);
        check("pre_reset_count", 32'(got_q.size()), 32'd9);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bif_m.byte_valid), 32'd0);
        check("midrst_busy", 32'(busy_m), 32'd0);
        check("midrst_ready", 32'(cif_m.char_ready), 32'd1);
        check("midrst_data", 32'({bif_m.byte_dc, bif_m.byte_data}), 32'd0);
        got_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add_expected(7'h41, 4'd1, 2'd0, 1'b0);
        send_char(7'h41, 4'd1, 2'd0, 1'b0);
        wait_done(14);
        compare_streams("after_reset_A");

        // Random requests with random backpressure.
        for (int r = 0; r < 40; r++) begin
            logic [6:0] rc;
            logic [3:0] rcol;
            logic [1:0] rpg;
            logic       rinv;
            rc   = 7'($urandom_range(0, 127));
            rcol = 4'($urandom_range(0, 15));
            rpg  = 2'($urandom_range(0, 3));
            rinv = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            add_expected(rc, rcol, rpg, rinv);
            send_char(rc, rcol, rpg, rinv);
            wait_done(14);
            compare_streams($sformatf("rand%0d_c%0h", r, rc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
